boot_sequencer: RTL and testbench

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

---
 rtl/bd8_boot_pkg.sv | 20 ++
 rtl/boot_sequencer_if.sv | 30 +++
 rtl/boot_sequencer_sync3.sv | 22 ++
 rtl/boot_sequencer.sv | 139 +++++++++++++
 tb/tb_boot_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bd8_boot_pkg.sv
// Shared definitions for the board boot sequencer: state encodings
// and the default timing parameters.
package bd8_boot_pkg;

    localparam int SETTLE_CYCLES_DEFAULT = 8191;
    localparam int LOAD_TIMEOUT_DEFAULT  = 1048575;
    localparam int RETRY_MAX_DEFAULT     = 3;

    // Encodings are visible on boot_state, so they are fixed explicitly.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETTLE    = 3'd1,
        LATCH     = 3'd2,
        LOAD_REQ  = 3'd3,
        LOAD_WAIT = 3'd4,
        READY     = 3'd5,
        FAULT     = 3'd6
    } bootState_e;

endpackage

// File: rtl/boot_sequencer_if.sv
// Request/response link between the boot sequencer and the SPI image loader.
//
// Handshake: load_req is a level request that stays high, with load_image
// stable, until load_ack is seen high on a clock edge; that edge completes
// the request. After acceptance the loader answers with exactly one
// single-cycle pulse on load_done (success) or load_error (failure).
// Responses that arrive while no request has been accepted carry no meaning.
interface boot_sequencer_if;
    logic       load_req;
    logic [2:0] load_image;
    logic       load_ack;
    logic       load_done;
    logic       load_error;

    modport master (
        output load_req,
        output load_image,
        input  load_ack,
        input  load_done,
        input  load_error
    );

    modport slave (
        input  load_req,
        input  load_image,
        output load_ack,
        output load_done,
        output load_error
    );
endinterface

// File: rtl/boot_sequencer_sync3.sv
// Three-flop synchroniser for the asynchronous power_good board signal.
// Resets to 1 so the sequencer treats power as not good until the real
// level has propagated through all three stages.
module sync3 (
    input  logic master_clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [2:0] stages;

    // Shift the raw input through the chain; reset preloads "power not good".
    always_ff @(posedge master_clock) begin
        if (reset) begin
            stages <= 3'b111;
        end else begin
            stages <= {stages[1:0], d};
        end
    end

    assign q = stages[2];
endmodule

// File: rtl/boot_sequencer.sv
// Board boot sequencer: waits for stable power, latches the selected image
// from the DIP switches, asks the SPI loader to load it (with timeout and
// bounded retries) and signals READY or a sticky FAULT.
module boot_sequencer
    import bd8_boot_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
    parameter int LOAD_TIMEOUT  = LOAD_TIMEOUT_DEFAULT,
    parameter int RETRY_MAX     = RETRY_MAX_DEFAULT
) (
    input  logic             master_clock,
    input  logic             reset,
    input  logic             power_good,
    input  logic [2:0]       image_dip_switch,
    boot_sequencer_if.master loadBus,
    output logic             temperature_low,
    output logic             fault,
    output logic [2:0]       boot_state
);

    localparam int SETTLE_W  = $clog2(SETTLE_CYCLES) + 1;
    localparam int TIMEOUT_W = $clog2(LOAD_TIMEOUT) + 1;
    localparam int RETRY_W   = $clog2(RETRY_MAX) + 1;

    // Last count value of each window; the transition fires in that cycle.
    localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(LOAD_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0]   RETRY_LAST   = RETRY_W'(RETRY_MAX - 1);

    bootState_e           state;
    logic                 pgSync;
    logic                 loadReqR;
    logic [2:0]           loadImageR;
    logic                 tempLowR;
    logic                 faultR;
    logic [SETTLE_W-1:0]  settleCnt;
    logic [TIMEOUT_W-1:0] timeoutCnt;
    logic [RETRY_W-1:0]   retryCnt;
    logic                 timeoutHit;

    sync3 powerSync (
        .master_clock (master_clock),
        .reset        (reset),
        .d            (power_good),
        .q            (pgSync)
    );

    // This cycle is the LOAD_TIMEOUT-th one spent waiting in this attempt.
    assign timeoutHit = (timeoutCnt == TIMEOUT_LAST);

    // Boot FSM with registered outputs and saturating counters.
    always_ff @(posedge master_clock) begin
        if (reset) begin
            state      <= IDLE;
            loadReqR   <= 1'b0;
            loadImageR <= 3'b000;
            tempLowR   <= 1'b0;
            faultR     <= 1'b0;
            settleCnt  <= '0;
            timeoutCnt <= '0;
            retryCnt   <= '0;
        end else if (pgSync && (state != FAULT)) begin
            // Power lost: abandon whatever was in progress and start over.
            state      <= IDLE;
            loadReqR   <= 1'b0;
            tempLowR   <= 1'b0;
            settleCnt  <= '0;
            timeoutCnt <= '0;
            retryCnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Reaching here means pgSync is low: power is good.
                    state     <= SETTLE;
                    settleCnt <= '0;
                end
                SETTLE: begin
                    if (settleCnt == SETTLE_LAST) begin
                        state <= LATCH;
                    end else if (settleCnt != '1) begin
                        settleCnt <= settleCnt + 1'b1;
                    end
                end
                LATCH: begin
                    // Switches are active low; this is the only place the image is taken.
                    loadImageR <= ~image_dip_switch;
                    loadReqR   <= 1'b1;
                    state      <= LOAD_REQ;
                end
                LOAD_REQ: begin
                    // done/error before an ack belong to no request and are dropped.
                    if (loadBus.load_ack) begin
                        loadReqR   <= 1'b0;
                        timeoutCnt <= '0;
                        state      <= LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    // Success is checked first so it beats an error or timeout in the same cycle.
                    if (loadBus.load_done) begin
                        tempLowR <= 1'b1;
                        state    <= READY;
                    end else if (loadBus.load_error || timeoutHit) begin
                        if (retryCnt != '1) begin
                            retryCnt <= retryCnt + 1'b1;
                        end
                        if (retryCnt >= RETRY_LAST) begin
                            faultR <= 1'b1;
                            state  <= FAULT;
                        end else begin
                            loadReqR <= 1'b1;
                            state    <= LOAD_REQ;
                        end
                    end else if (timeoutCnt != '1) begin
                        timeoutCnt <= timeoutCnt + 1'b1;
                    end
                end
                READY: begin
                    // Held until power drops or reset.
                end
                FAULT: begin
                    // Sticky; only reset leaves this state.
                end
                default: begin
                    loadReqR <= 1'b0;
                    tempLowR <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign loadBus.load_req   = loadReqR;
    assign loadBus.load_image = loadImageR;
    assign temperature_low    = tempLowR;
    assign fault              = faultR;
    assign boot_state         = state;

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: directed boot scenarios followed by randomized
// boots, checked against an attempt-level model of the boot rules.
module tb_boot_sequencer;

    localparam int SETTLE_N  = 8191;
    localparam int TIMEOUT_N = 16;
    localparam int RETRIES   = 3;

    localparam int ST_IDLE      = 0;
    localparam int ST_SETTLE    = 1;
    localparam int ST_LATCH     = 2;
    localparam int ST_LOAD_REQ  = 3;
    localparam int ST_LOAD_WAIT = 4;
    localparam int ST_READY     = 5;
    localparam int ST_FAULT     = 6;

    // Loader responses to one accepted request.
    localparam int K_DONE    = 0;
    localparam int K_ERROR   = 1;
    localparam int K_TIMEOUT = 2;
    localparam int K_BOTH    = 3;

    logic       master_clock = 1'b0;
    logic       reset;
    logic       power_good;
    logic [2:0] image_dip_switch;
    logic       temperature_low;
    logic       fault;
    logic [2:0] boot_state;

    int         checkCount = 0;
    int         errorCount = 0;
    logic [2:0] expImageQ[$];
    logic [2:0] lastImage;

    boot_sequencer_if loadBus();

    boot_sequencer #(
        .SETTLE_CYCLES (SETTLE_N),
        .LOAD_TIMEOUT  (TIMEOUT_N),
        .RETRY_MAX     (RETRIES)
    ) dut (
        .master_clock     (master_clock),
        .reset            (reset),
        .power_good       (power_good),
        .image_dip_switch (image_dip_switch),
        .loadBus          (loadBus),
        .temperature_low  (temperature_low),
        .fault            (fault),
        .boot_state       (boot_state)
    );

    // Clock and reset
    always #5 master_clock = ~master_clock;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checkCount, errorCount);
        $fatal(1);
    end

    task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Inputs are driven and outputs sampled just after the falling edge.
    task automatic tick(input int n = 1);
        repeat (n) @(negedge master_clock);
    endtask

    task automatic pulse(input logic ack, input logic done, input logic err);
        loadBus.load_ack   = ack;
        loadBus.load_done  = done;
        loadBus.load_error = err;
        tick();
        loadBus.load_ack   = 1'b0;
        loadBus.load_done  = 1'b0;
        loadBus.load_error = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkValue({tag, "_state"}, boot_state, ST_IDLE);
        checkValue({tag, "_load_req"}, loadBus.load_req, 0);
        checkValue({tag, "_load_image"}, loadBus.load_image, 0);
        checkValue({tag, "_temp_low"}, temperature_low, 0);
        checkValue({tag, "_fault"}, fault, 0);
    endtask

    task automatic applyReset(input string tag);
        reset = 1'b1;
        tick();
        checkResetValues(tag);
        reset = 1'b0;
    endtask

    // Power cycle into a fresh boot and follow it until the request is raised.
    task automatic bootToLatch(input logic [2:0] dip, input string tag);
        int         waited;
        logic [2:0] expImage;
        power_good = 1'b1;
        tick(6);
        checkValue({tag, "_idle_before_boot"}, boot_state, ST_IDLE);
        image_dip_switch = dip;
        expImageQ.push_back(~dip);
        power_good = 1'b0;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (boot_state !== 3'(ST_LATCH) && waited < SETTLE_N + 40);
        // 3 sync edges, 1 edge leaving IDLE, SETTLE_N cycles of settling.
        checkValue({tag, "_latch_delay"}, waited, SETTLE_N + 4);
        tick();
        expImage  = expImageQ.pop_front();
        lastImage = expImage;
        checkValue({tag, "_load_image"}, loadBus.load_image, expImage);
        checkValue({tag, "_req_raised"}, loadBus.load_req, 1);
        checkValue({tag, "_req_state"}, boot_state, ST_LOAD_REQ);
        // Switch changes after the latch point must not reach load_image.
        image_dip_switch = 3'($urandom_range(0, 7));
    endtask

    // One load attempt: request phase, ack, loader response, then compare the
    // resulting outputs with the attempt-level boot rules.
    task automatic attempt(input int ackDelay, input bit stray, input int kind, input int waitTicks,
                           input int attemptNo, input string tag, output bit finished);
        int expState;
        for (int i = 0; i < ackDelay; i++) begin
            if (stray && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) loadBus.load_done = 1'b1;
                else loadBus.load_error = 1'b1;
            end
            tick();
            loadBus.load_done  = 1'b0;
            loadBus.load_error = 1'b0;
            checkValue({tag, "_req_held"}, loadBus.load_req, 1);
        end
        checkValue({tag, "_still_requesting"}, boot_state, ST_LOAD_REQ);
        pulse(1'b1, 1'b0, 1'b0);
        checkValue({tag, "_ack_state"}, boot_state, ST_LOAD_WAIT);
        checkValue({tag, "_ack_req_drop"}, loadBus.load_req, 0);
        if (kind == K_TIMEOUT) begin
            tick(TIMEOUT_N - 1);
            checkValue({tag, "_before_timeout"}, boot_state, ST_LOAD_WAIT);
            tick();
        end else begin
            tick(waitTicks);
            pulse(1'b0, (kind == K_DONE || kind == K_BOTH), (kind == K_ERROR || kind == K_BOTH));
        end
        if (kind == K_DONE || kind == K_BOTH) expState = ST_READY;
        else if (attemptNo >= RETRIES) expState = ST_FAULT;
        else expState = ST_LOAD_REQ;
        checkValue({tag, "_outcome_state"}, boot_state, expState);
        checkValue({tag, "_outcome_req"}, loadBus.load_req, (expState == ST_LOAD_REQ));
        checkValue({tag, "_outcome_temp"}, temperature_low, (expState == ST_READY));
        checkValue({tag, "_outcome_fault"}, fault, (expState == ST_FAULT));
        finished = (expState != ST_LOAD_REQ);
    endtask

    task automatic checkDipIgnored(input string tag);
        image_dip_switch = ~image_dip_switch;
        tick(3);
        checkValue({tag, "_image_kept"}, loadBus.load_image, lastImage);
        checkValue({tag, "_still_ready"}, temperature_low, 1);
    endtask

    initial begin
        bit fin;
        int n;
        int kind;
        int r;

        reset              = 1'b1;
        power_good         = 1'b1;
        image_dip_switch   = 3'b000;
        loadBus.load_ack   = 1'b0;
        loadBus.load_done  = 1'b0;
        loadBus.load_error = 1'b0;
        tick(2);
        checkResetValues("por");
        reset = 1'b0;

        // Boot 1: DIP 101 -> image 010, ack after 5 cycles, done -> READY.
        bootToLatch(3'b101, "b1");
        attempt(5, 1'b0, K_DONE, 3, 1, "b1_a1", fin);
        checkDipIgnored("b1_ready");
        power_good = 1'b1;
        n = 0;
        while (temperature_low === 1'b1 && n < 6) begin
            tick();
            n++;
        end
        checkValue("b1_ready_drop_latency", n, 4);
        checkValue("b1_after_drop_state", boot_state, ST_IDLE);

        // Boot 2: re-latch a new DIP, long wait for ack with stray responses,
        // then three errors ending in FAULT.
        bootToLatch(3'b110, "b2");
        attempt(40, 1'b1, K_ERROR, 2, 1, "b2_a1", fin);
        attempt(2, 1'b0, K_ERROR, 0, 2, "b2_a2", fin);
        attempt(1, 1'b0, K_ERROR, 7, 3, "b2_a3", fin);
        power_good = 1'b1;
        tick(8);
        checkValue("b2_fault_sticky_state", boot_state, ST_FAULT);
        checkValue("b2_fault_sticky_flag", fault, 1);
        checkValue("b2_fault_no_req", loadBus.load_req, 0);
        checkValue("b2_fault_temp", temperature_low, 0);
        applyReset("b2_reset");

        // Boot 3: timeout retry, error retry, then done+error on the last try.
        bootToLatch(3'b011, "b3");
        attempt(0, 1'b0, K_TIMEOUT, 0, 1, "b3_a1", fin);
        attempt(3, 1'b0, K_ERROR, 0, 2, "b3_a2", fin);
        attempt(1, 1'b0, K_BOTH, 4, 3, "b3_a3", fin);

        // Boot 4: done arrives in the same cycle as the timeout.
        bootToLatch(3'b000, "b4");
        attempt(2, 1'b0, K_DONE, TIMEOUT_N - 1, 1, "b4_a1", fin);
        checkDipIgnored("b4_ready");

        // Boot 5: reset mid-wait, then the synchroniser must restart from "not good".
        bootToLatch(3'b111, "b5");
        tick(2);
        pulse(1'b1, 1'b0, 1'b0);
        checkValue("b5_wait_state", boot_state, ST_LOAD_WAIT);
        tick(5);
        applyReset("b5_reset");
        tick(3);
        checkValue("b5_sync_hold_state", boot_state, ST_IDLE);
        checkValue("b5_no_pending_req", loadBus.load_req, 0);
        tick();
        checkValue("b5_settle_after_sync", boot_state, ST_SETTLE);

        // Randomized boots.
        for (int b = 0; b < 3; b++) begin
            bootToLatch(3'($urandom_range(0, 7)), $sformatf("rnd%0d", b));
            fin = 1'b0;
            for (int a = 1; a <= RETRIES && !fin; a++) begin
                r = $urandom_range(0, 5);
                kind = (r == 0) ? K_DONE : (r == 1) ? K_BOTH : (r <= 3) ? K_ERROR : K_TIMEOUT;
                attempt($urandom_range(0, 6), 1'b1, kind, $urandom_range(0, TIMEOUT_N - 1), a,
                        $sformatf("rnd%0d_a%0d", b, a), fin);
            end
            if (fault === 1'b1) applyReset($sformatf("rnd%0d_reset", b));
            else checkDipIgnored($sformatf("rnd%0d_ready", b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
